// File: rtl/rs232_tx_arbiter.sv
// Shares one RS232 byte transmitter between N_REQ producers and acks each finished frame.
// Define RS232_TX_ARB_RR_EN for round-robin selection; otherwise the lowest index wins.
module rs232_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter int TMO_CYC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] din,
    output logic [N_REQ-1:0]   ack,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy,
    output logic               err,
    output logic [7:0]         tx_d,
    output logic               tx_stt,
    input  logic               tx_eot
);

    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SENDING,
        ST_ACK,
        ST_GAP
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   tmo_cnt_reg;
    logic [N_REQ-1:0]   ack_reg;
    logic [IDX_W-1:0]   gnt_idx_reg;
    logic               busy_reg;
    logic               err_reg;
    logic [7:0]         tx_d_reg;
    logic               tx_stt_reg;

    logic [7:0]         din_lane [N_REQ];
    logic [IDX_W-1:0]   win_idx;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign din_lane[gi] = din[8*gi +: 8];
        end
    endgenerate

`ifdef RS232_TX_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_reg;
    logic             rr_hit;
    int               rr_j;

    // First set request at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_idx = '0;
        rr_hit  = 1'b0;
        rr_j    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_j = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!rr_hit && req[rr_j]) begin
                rr_hit  = 1'b1;
                win_idx = IDX_W'(rr_j);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
            ack_reg     <= '0;
            gnt_idx_reg <= '0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            tx_d_reg    <= 8'h00;
            tx_stt_reg  <= 1'b0;
`ifdef RS232_TX_ARB_RR_EN
            rr_ptr_reg  <= '0;
`endif
        end else begin
            ack_reg <= '0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A low EOT here means someone else's frame is still on the line.
                    if (|req && tx_eot) begin
                        gnt_idx_reg <= win_idx;
                        tx_d_reg    <= din_lane[win_idx];
                        tmo_cnt_reg <= '0;
                        tx_stt_reg  <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (!tx_eot) begin
                        tx_stt_reg <= 1'b0;
                        state_reg  <= ST_SENDING;
                    end else if (tmo_cnt_reg == CNT_W'(TMO_CYC - 1)) begin
                        tx_stt_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        state_reg  <= ST_GAP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_SENDING: begin
                    if (tx_eot) begin
                        ack_reg[gnt_idx_reg] <= 1'b1;
                        state_reg            <= ST_ACK;
                    end
                end
                ST_ACK: begin
`ifdef RS232_TX_ARB_RR_EN
                    rr_ptr_reg <= (gnt_idx_reg == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_reg + 1'b1;
`endif
                    state_reg <= ST_GAP;
                end
                ST_GAP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg   <= 1'b0;
                    tx_stt_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack     = ack_reg;
    assign gnt_idx = gnt_idx_reg;
    assign busy    = busy_reg;
    assign err     = err_reg;
    assign tx_d    = tx_d_reg;
    assign tx_stt  = tx_stt_reg;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Randomized bench for rs232_tx_arbiter: a frame-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_rs232_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int IDX_W   = 2;
    localparam int TMO_CYC = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [8*N_REQ-1:0] din = '0;
    logic               tx_eot = 1'b1;
    logic [N_REQ-1:0]   ack;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;
    logic               err;
    logic [7:0]         tx_d;
    logic               tx_stt;

    int n_chk = 0;
    int n_fail = 0;

    // model expectations for the DUT outputs after the most recent clock edge
    logic [N_REQ-1:0] e_ack = '0;
    logic [IDX_W-1:0] e_gnt = '0;
    logic             e_busy = 1'b0;
    logic             e_err = 1'b0;
    logic             e_stt = 1'b0;
    logic [7:0]       e_d = 8'h00;
    int               rr_m = 0;

    // bench-side transmitter
    int xstate = 0;
    int xcnt = 0;
    int xdelay = 1;
    int xlen = 3;
    bit xrand = 1'b0;
    bit xdead = 1'b0;
    bit xforeign = 1'b0;

    rs232_tx_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .ack(ack), .gnt_idx(gnt_idx),
        .busy(busy), .err(err), .tx_d(tx_d), .tx_stt(tx_stt), .tx_eot(tx_eot)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [N_REQ-1:0] r, int p);
        for (int k = 0; k < N_REQ; k++) begin
`ifdef RS232_TX_ARB_RR_EN
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
`else
            if (r[k]) return k;
`endif
        end
        return 0;
    endfunction

    task automatic mtick(output bit ab);
        @(posedge clk);
        ab = reset;
        if (reset) begin
            e_ack = '0; e_gnt = '0; e_busy = 1'b0; e_err = 1'b0; e_stt = 1'b0; e_d = 8'h00;
            rr_m = 0;
        end
    endtask

    // Frame timeline: wait for a grant, launch, send, ack, gap.
    initial begin : model
        int w;
        bit ab;
        bit started;
        forever begin
            e_busy = 1'b0; e_stt = 1'b0; e_ack = '0; e_err = 1'b0;
            mtick(ab);
            if (ab) continue;
            if (!(|req && tx_eot)) continue;
            w = pick(req, rr_m);
            e_gnt = IDX_W'(w); e_d = din[8*w +: 8]; e_busy = 1'b1; e_stt = 1'b1;
            started = 1'b0;
            for (int n = 0; n < TMO_CYC; n++) begin
                mtick(ab);
                if (ab) break;
                if (!tx_eot) begin
                    started = 1'b1;
                    break;
                end
            end
            if (ab) continue;
            e_stt = 1'b0;
            if (!started) begin
                e_err = 1'b1;
                mtick(ab);
                continue;
            end
            do mtick(ab); while (!ab && !tx_eot);
            if (ab) continue;
            e_ack = '0; e_ack[w] = 1'b1;
            mtick(ab);
            if (ab) continue;
            e_ack = '0;
            rr_m = (w + 1) % N_REQ;
            mtick(ab);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_all();
        if (reset) begin
            chk("rst_ack", 32'(ack), 0);
            chk("rst_gnt", 32'(gnt_idx), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_tx_d", 32'(tx_d), 0);
            chk("rst_tx_stt", 32'(tx_stt), 0);
        end else begin
            chk("ack", 32'(ack), 32'(e_ack));
            chk("gnt_idx", 32'(gnt_idx), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("err", 32'(err), 32'(e_err));
            chk("tx_d", 32'(tx_d), 32'(e_d));
            chk("tx_stt", 32'(tx_stt), 32'(e_stt));
        end
    endtask

    task automatic xmit_update();
        if (xforeign) begin
            tx_eot = 1'b0;
            xstate = 0;
        end else begin
            case (xstate)
                0: begin
                    tx_eot = 1'b1;
                    if (tx_stt) begin
                        if (xdead || (xrand && $urandom_range(0, 15) == 0)) begin
                            xstate = 3;
                        end else begin
                            if (xrand) begin
                                xdelay = $urandom_range(0, 3);
                                xlen   = $urandom_range(1, 6);
                            end
                            xcnt = xdelay;
                            xstate = 1;
                        end
                    end
                end
                1: if (xcnt == 0) begin tx_eot = 1'b0; xcnt = xlen; xstate = 2; end else xcnt--;
                2: if (xcnt == 0) begin tx_eot = 1'b1; xstate = 0; end else xcnt--;
                default: if (!tx_stt) xstate = 0;
            endcase
        end
    endtask

    // compare mid-cycle, then advance to just after the next rising edge
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #2;
        xmit_update();
    endtask

    task automatic wait_ack(logic [N_REQ-1:0] expv, bit drop);
        for (int i = 0; i < 40; i++) begin
            if (ack != '0) break;
            step();
        end
        chk("ack_onehot", 32'(ack), 32'(expv));
        if (drop) req = req & ~expv;
        step();
        chk("ack_pulse", 32'(ack), 0);
    endtask

    task automatic wait_stt();
        for (int i = 0; i < 20; i++) begin
            if (tx_stt) break;
            step();
        end
        chk("stt_seen", 32'(tx_stt), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_eot = 1'b1; xstate = 0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin : stim
        int n;
        step(); step();
        reset = 1'b0;

        // single request on lane 2
        xdelay = 1; xlen = 3;
        req = 4'b0100; din[23:16] = 8'hA5;
        step();
        chk("t1_stt", 32'(tx_stt), 1);
        chk("t1_tx_d", 32'(tx_d), 32'h A5);
        chk("t1_gnt", 32'(gnt_idx), 2);
        chk("t1_busy", 32'(busy), 1);
        wait_ack(4'b0100, 1'b1);

        // arbitration under contention
        do_reset();
        din = 32'h44_33_22_11;
`ifdef RS232_TX_ARB_RR_EN
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_stt();
            chk("t2_rr_gnt", 32'(gnt_idx), f % 4);
            wait_ack(4'(1 << (f % 4)), 1'b0);
        end
`else
        req = 4'b1010;
        for (int f = 0; f < 3; f++) begin
            wait_stt();
            chk("t2_fixed_gnt", 32'(gnt_idx), 1);
            wait_ack(4'b0010, 1'b0);
        end
`endif
        req = '0;
        step(); step(); step();

        // dead transmitter: timeout, err, retry of the same requester
        xdead = 1'b1;
        req = 4'b0100; din[23:16] = 8'h11;
        wait_stt();
        n = 0;
        while (tx_stt && n < 20) begin
            n++;
            step();
        end
        chk("t3_stt_len", 32'(n), TMO_CYC);
        chk("t3_err", 32'(err), 1);
        chk("t3_no_ack", 32'(ack), 0);
        step();
        chk("t3_err_pulse", 32'(err), 0);
        wait_stt();
        chk("t3_regrant", 32'(gnt_idx), 2);
        xdead = 1'b0; xstate = 0;
        wait_ack(4'b0100, 1'b1);
        step(); step();

        // foreign frame on the line holds off the launch
        xforeign = 1'b1; tx_eot = 1'b0;
        req = 4'b0001; din[7:0] = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stt_low", 32'(tx_stt), 0);
            chk("t4_idle", 32'(busy), 0);
        end
        xforeign = 1'b0; tx_eot = 1'b1;
        step();
        chk("t4_stt", 32'(tx_stt), 1);
        chk("t4_gnt", 32'(gnt_idx), 0);
        wait_ack(4'b0001, 1'b1);
        step(); step();

        // asynchronous reset in the middle of a frame
        xdelay = 1; xlen = 8;
        req = 4'b0010; din[15:8] = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            if (busy && !tx_stt && !tx_eot) break;
            step();
        end
        chk("t5_sending", 32'(busy && !tx_stt && !tx_eot), 1);
        reset = 1'b1;
        #1;
        chk("t5_ack", 32'(ack), 0);
        chk("t5_stt", 32'(tx_stt), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_tx_d", 32'(tx_d), 0);
        tx_eot = 1'b1; xstate = 0;
        step(); step();
        reset = 1'b0;
        step();
        chk("t5_relaunch", 32'(tx_stt), 1);
        chk("t5_tx_d2", 32'(tx_d), 32'h5A);
        chk("t5_gnt", 32'(gnt_idx), 1);
        wait_ack(4'b0010, 1'b1);
        step(); step();

        // byte change after grant is ignored
        xdelay = 2; xlen = 4;
        req = 4'b1000; din[31:24] = 8'h77;
        step();
        chk("t6_tx_d", 32'(tx_d), 32'h77);
        din[31:24] = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            if (ack != '0) break;
            step();
        end
        chk("t6_ack", 32'(ack), 32'b1000);
        chk("t6_tx_d_hold", 32'(tx_d), 32'h77);
        req = '0;
        step(); step(); step();

        // randomized traffic
        xrand = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i]) begin
                    req[i] = ($urandom_range(0, 2) == 0);
                    din[8*i +: 8] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    din[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    din[8*i +: 8] = 8'($urandom);
                end
            end
        end
        req = '0;
        for (int i = 0; i < 40; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
